// File: rtl/hazard_scoreboard.sv
// Register scoreboard between decode and the writeback delay line: holds issue
// while an older in-flight instruction still owes a write to a source register.
module hazard_scoreboard #(
  parameter int LATENCY = 3,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rs1,
  input  logic             issue_rs1_used,
  input  logic [4:0]       issue_rs2,
  input  logic             issue_rs2_used,
  input  logic [4:0]       issue_rd,
  input  logic             issue_rd_we,
  input  logic             flush,
  output logic             issue_ready,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [CNT_W-1:0] stall_count
);

  logic [LATENCY-1:0] slot_valid;
  logic [4:0]         slot_rd [LATENCY];
  logic               rs1_hit;
  logic               rs2_hit;
  logic               hazard;
  logic               fire;

  // The exit slot is still pending: its write lands after decode reads the file.
  always_comb begin
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      if (slot_valid[i] && slot_rd[i] == issue_rs1) rs1_hit = 1'b1;
      if (slot_valid[i] && slot_rd[i] == issue_rs2) rs2_hit = 1'b1;
    end
  end

  assign hazard      = (issue_rs1_used && issue_rs1 != 5'd0 && rs1_hit) ||
                       (issue_rs2_used && issue_rs2 != 5'd0 && rs2_hit);
  assign issue_ready = !hazard && !flush;
  assign fire        = issue_valid && issue_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        slot_valid[i] <= 1'b0;
        slot_rd[i]    <= 5'd0;
      end
    end else begin
      if (fire) begin
        slot_valid[0] <= issue_rd_we && issue_rd != 5'd0;
        slot_rd[0]    <= issue_rd;
      end else begin
        slot_valid[0] <= 1'b0;
        slot_rd[0]    <= 5'd0;
      end
      // A flush squashes the youngest entry as it moves out of slot 0.
      for (int i = 1; i < LATENCY; i++) begin
        if (i == 1 && flush) begin
          slot_valid[i] <= 1'b0;
          slot_rd[i]    <= 5'd0;
        end else begin
          slot_valid[i] <= slot_valid[i-1];
          slot_rd[i]    <= slot_rd[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (issue_valid && hazard && !flush && stall_count != '1) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

  assign wb_valid = slot_valid[LATENCY-1];
  assign wb_rd    = slot_rd[LATENCY-1];

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

- Tracks destination registers of instructions in flight between issue and register-file writeback.
- Decode presents each instruction's source operands here; the block holds issue until no older in-flight instruction still owes a write to a source register.
- Sits between decode and the 3-deep writeback delay line. Its exit slot reproduces the destination-register index the delay line delivers to the register file, so the two can be cross-checked.

## Interface

Parameters:
- `LATENCY`, default 3: cycles from issue to register-file write; legal range 1..8.
- `CNT_W`, default 16: width of the stall counter.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low. Low clears all state immediately, independent of `clk`.
- `issue_valid` in 1: decode presents an instruction this cycle.
- `issue_rs1` in 5: source register 1 index.
- `issue_rs1_used` in 1: instruction reads rs1.
- `issue_rs2` in 5: source register 2 index.
- `issue_rs2_used` in 1: instruction reads rs2.
- `issue_rd` in 5: destination register index.
- `issue_rd_we` in 1: instruction writes rd.
- `flush` in 1: squash the youngest in-flight instruction and block issue this cycle.
- `issue_ready` out 1: combinational; instruction may issue.
- `wb_valid` out 1: the exit slot holds a live write.
- `wb_rd` out 5: destination index in the exit slot.
- `stall_count` out CNT_W: saturating count of stall cycles.

## Operation

- **Tracker.** State is a shift line of `LATENCY` slots, each holding {valid, rd}.
  - Slot 0 is the youngest entry; slot `LATENCY-1` is the exit slot.
  - The line shifts by one every cycle and never stalls. Writeback is not back-pressured.
- **Issue fire.** Issue fires when `issue_valid && issue_ready`.
  - On a fire, slot 0 loads {`issue_rd_we && issue_rd != 0`, `issue_rd`}.
  - Otherwise slot 0 loads {0, 0}.
  - Register x0 is never tracked.
- **Pending.** Register r is pending when any valid slot (0..`LATENCY-1`) holds rd == r.
  - The exit slot counts as pending: its write lands at the end of the current cycle, after decode has read the register file.
- **Hazard.** A hazard exists when either of these holds:
  - `issue_rs1_used && issue_rs1 != 0 && pending(issue_rs1)`
  - `issue_rs2_used && issue_rs2 != 0 && pending(issue_rs2)`
- **`issue_ready`** is `!hazard && !flush`. It does not depend on `issue_valid`.
- **Flush.** While `flush` = 1:
  - the entry leaving slot 0 is dropped (slot 1 loads invalid);
  - slot 0 loads invalid;
  - no issue fires.
  - Older slots shift normally; their writes still complete.
- **`wb_valid` / `wb_rd`** are registered outputs equal to the exit slot contents.
- **`stall_count`** increments on every cycle with `issue_valid && hazard && !flush`.
  - It saturates at 2^CNT_W-1.
  - Only reset clears it.
  - Flush cycles are not counted.

## Timing

- Instruction issued on edge k:
  - is in slot 0 after edge k;
  - drives `wb_valid`=1 and `wb_rd` after edge k+`LATENCY`-1;
  - leaves the tracker at edge k+`LATENCY`.
- A dependent instruction presented in the cycle immediately after its producer stalls exactly `LATENCY` cycles.
- A dependent instruction presented j cycles later (j ≤ `LATENCY`) stalls `LATENCY`-j+1 cycles. At j > `LATENCY` it does not stall.
- `issue_ready` is a same-cycle combinational function of the inputs and slot state, with no added latency.
- A write-after-write to the same rd is tracked as two independent slots. The register stays pending until the younger slot exits.
- **Reset values** (`reset` low): all slots invalid, `wb_valid`=0, `wb_rd`=0, `stall_count`=0.
  - `issue_ready` then evaluates to `!flush`.
- **Reset asserted mid-operation** discards all in-flight entries without a clock edge. Issue may resume on the first edge after `reset` returns high.

## Test plan

- **RAW stall, `LATENCY`=3.**
  - Stimulus: issue rd=5 (we=1) in cycle 0; present rs1=5, rs1_used=1 from cycle 1 on.
  - Response: `issue_ready`=0 in cycles 1-3 and 1 in cycle 4; `wb_valid`=1 with `wb_rd`=5 in cycle 3 only; `stall_count`=3.
- **x0 and unused operands.**
  - Stimulus: issue rd=0 (we=1), then rs1=0 used; separately issue rd=9, then rs2=9 with rs2_used=0.
  - Response: `issue_ready`=1 throughout; `wb_valid` never 1 for rd=0; `stall_count`=0.
- **Flush.**
  - Stimulus: issue rd=7 in cycle 0; in cycle 1 assert `flush`=1 with a rs1=7 consumer presented.
  - Response: `issue_ready`=0 in cycle 1 and 1 in cycle 2; `wb_valid` stays 0 for the whole rd=7 lifetime; `stall_count`=0.
- **Asynchronous reset mid-flight.**
  - Stimulus: issue rd=3, rd=4 back to back; pull `reset` low between clock edges.
  - Response: `wb_valid`=0, `wb_rd`=0, `stall_count`=0 before the next edge; after release, a rs1=3 consumer issues with no stall.
- **WAW plus distance.**
  - Stimulus: issue rd=6 in cycles 0 and 1; present a rs1=6 consumer in cycle 2.
  - Response: the consumer stalls in cycles 2-4 and issues in cycle 5; `wb_rd`=6 with `wb_valid`=1 in cycles 3 and 4.
- **Counter saturation.**
  - Stimulus: `CNT_W`=4; a chain of dependent instructions giving 20 stall cycles.
  - Response: `stall_count` reaches 15 and holds at 15.
